// File: rtl/int_issue_queue_pkg.sv
// Shared definitions for the integer issue queue.
// Provides the operand/entry widths, the ALU opcode encodings and the packed
// queue-entry layout used by the queue, its slots and the issue unit.
// It also provides the CDB capture rule shared by wakeup and dispatch bypass.
package int_issue_queue_pkg;

    localparam int unsigned TAG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4,
        ALU_SLL = 4'h5,
        ALU_SRL = 4'h6,
        ALU_SLT = 4'h7
    } alu_op_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              rdy;
    } iq_opnd_t;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   opcode;
        logic [TAG_W-1:0]  rd_tag;
        iq_opnd_t          rs;
        iq_opnd_t          rt;
    } iq_entry_t;

    // A waiting operand captures a matching CDB broadcast; ready operands keep their value.
    function automatic iq_opnd_t opnd_wake(iq_opnd_t o, logic cdb_valid,
                                           logic [TAG_W-1:0] cdb_tag,
                                           logic [DATA_W-1:0] cdb_data);
        iq_opnd_t r;
        r = o;
        if (cdb_valid && !o.rdy && (o.tag == cdb_tag)) begin
            r.data = cdb_data;
            r.rdy  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/int_issue_queue_if.sv
// Handshake bundle between the dispatch stage, the CDB, the issue unit and
// one integer issue queue.
// The slave modport is the queue side.
// The master modport is the side that drives dispatch, CDB and grant.
interface int_issue_queue_if;
    import int_issue_queue_pkg::*;

    logic              Dispatch_Valid;
    logic [OP_W-1:0]   Dispatch_Opcode;
    logic [TAG_W-1:0]  Dispatch_RdTag;
    logic [TAG_W-1:0]  Dispatch_RsTag;
    logic [DATA_W-1:0] Dispatch_RsData;
    logic              Dispatch_RsReady;
    logic [TAG_W-1:0]  Dispatch_RtTag;
    logic [DATA_W-1:0] Dispatch_RtData;
    logic              Dispatch_RtReady;
    logic              Queue_Full;
    logic              CDB_Valid;
    logic [TAG_W-1:0]  CDB_Tag;
    logic [DATA_W-1:0] CDB_Data;
    logic              Ready_Int;
    logic              Issue_Int;
    logic [OP_W-1:0]   Issue_Opcode;
    logic [TAG_W-1:0]  Issue_RdTag;
    logic [DATA_W-1:0] Issue_RsData;
    logic [DATA_W-1:0] Issue_RtData;

    modport slave (
        input  Dispatch_Valid, Dispatch_Opcode, Dispatch_RdTag,
               Dispatch_RsTag, Dispatch_RsData, Dispatch_RsReady,
               Dispatch_RtTag, Dispatch_RtData, Dispatch_RtReady,
               CDB_Valid, CDB_Tag, CDB_Data, Issue_Int,
        output Queue_Full, Ready_Int, Issue_Opcode, Issue_RdTag,
               Issue_RsData, Issue_RtData
    );

    modport master (
        output Dispatch_Valid, Dispatch_Opcode, Dispatch_RdTag,
               Dispatch_RsTag, Dispatch_RsData, Dispatch_RsReady,
               Dispatch_RtTag, Dispatch_RtData, Dispatch_RtReady,
               CDB_Valid, CDB_Tag, CDB_Data, Issue_Int,
        input  Queue_Full, Ready_Int, Issue_Opcode, Issue_RdTag,
               Issue_RsData, Issue_RtData
    );

endinterface

// File: rtl/int_issue_queue_iq_entry.sv
// One issue-queue slot.
// Ports:
//   Clk, Rst_n  - clock and asynchronous active-low reset
//   Flush       - clears the slot
//   Load_En     - take Load_Entry (new dispatch)
//   Shift_En    - take Upper (the next-younger slot)
//   Upper       - contents of the next-younger slot
//   Load_Entry  - dispatch contents
//   Cdb_*       - CDB broadcast
//   Slot        - registered slot contents
// The CDB capture is applied to whichever source the slot takes this edge.
// That source can be the held entry, the shifted entry or the dispatched entry.
// Applying it to the dispatched entry gives the dispatch bypass.
module iq_entry
    import int_issue_queue_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,
    input  logic              Load_En,
    input  logic              Shift_En,
    input  iq_entry_t         Upper,
    input  iq_entry_t         Load_Entry,
    input  logic              Cdb_Valid,
    input  logic [TAG_W-1:0]  Cdb_Tag,
    input  logic [DATA_W-1:0] Cdb_Data,
    output iq_entry_t         Slot
);

    iq_entry_t src;
    iq_entry_t nxt;

    always_comb begin
        src = Slot;
        if (Load_En) begin
            src = Load_Entry;
        end else if (Shift_En) begin
            src = Upper;
        end
        nxt    = src;
        nxt.rs = opnd_wake(src.rs, Cdb_Valid & src.valid, Cdb_Tag, Cdb_Data);
        nxt.rt = opnd_wake(src.rt, Cdb_Valid & src.valid, Cdb_Tag, Cdb_Data);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Slot <= '0;
        end else if (Flush) begin
            Slot <= '0;
        end else begin
            Slot <= nxt;
        end
    end

endmodule

// File: rtl/int_issue_queue.sv
// Integer-lane issue queue.
// It holds dispatched ops in age order, with slot 0 the oldest.
// It captures operands from the CDB.
// It offers the oldest fully-ready op to the issue unit.
// Ports:
//   Clk, Rst_n - clock and asynchronous active-low reset
//   Flush      - synchronous clear of every entry
//   iq         - dispatch inputs, CDB, issue grant, Queue_Full, Ready_Int and Issue_* fields
module int_issue_queue
    import int_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic               Clk,
    input logic               Rst_n,
    input logic               Flush,
    int_issue_queue_if.slave  iq
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    iq_entry_t         slot [DEPTH];
    iq_entry_t         upper [DEPTH];
    iq_entry_t         load_entry;
    logic [DEPTH-1:0]  load_en;
    logic [DEPTH-1:0]  shift_en;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  wr_idx;
    logic              full_q;
    logic              ready;
    logic [IDX_W-1:0]  sel_idx;
    logic              issue_go;
    logic              disp_go;

    // Oldest-first select over registered slot state only.
    always_comb begin
        ready   = 1'b0;
        sel_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!ready && slot[i].valid && slot[i].rs.rdy && slot[i].rt.rdy) begin
                ready   = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        issue_go = iq.Issue_Int & ready;
        disp_go  = iq.Dispatch_Valid & ~full_q;
        // An issue in the same edge frees a slot below, so the new op lands one lower.
        wr_idx   = count_q - CNT_W'(issue_go);
        count_d  = count_q + CNT_W'(disp_go) - CNT_W'(issue_go);
    end

    always_comb begin
        load_entry           = '0;
        load_entry.valid     = 1'b1;
        load_entry.opcode    = iq.Dispatch_Opcode;
        load_entry.rd_tag    = iq.Dispatch_RdTag;
        load_entry.rs.tag    = iq.Dispatch_RsTag;
        load_entry.rs.data   = iq.Dispatch_RsData;
        load_entry.rs.rdy    = iq.Dispatch_RsReady;
        load_entry.rt.tag    = iq.Dispatch_RtTag;
        load_entry.rt.data   = iq.Dispatch_RtData;
        load_entry.rt.rdy    = iq.Dispatch_RtReady;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == DEPTH - 1) begin : g_top
            assign upper[i] = '0;
        end else begin : g_mid
            assign upper[i] = slot[i+1];
        end
        assign shift_en[i] = issue_go & (sel_idx <= IDX_W'(i));
        assign load_en[i]  = disp_go & (wr_idx == CNT_W'(i));

        iq_entry u_entry (
            .Clk        (Clk),
            .Rst_n      (Rst_n),
            .Flush      (Flush),
            .Load_En    (load_en[i]),
            .Shift_En   (shift_en[i]),
            .Upper      (upper[i]),
            .Load_Entry (load_entry),
            .Cdb_Valid  (iq.CDB_Valid),
            .Cdb_Tag    (iq.CDB_Tag),
            .Cdb_Data   (iq.CDB_Data),
            .Slot       (slot[i])
        );
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else if (Flush) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    assign iq.Queue_Full   = full_q;
    assign iq.Ready_Int    = ready;
    assign iq.Issue_Opcode = ready ? slot[sel_idx].opcode  : '0;
    assign iq.Issue_RdTag  = ready ? slot[sel_idx].rd_tag  : '0;
    assign iq.Issue_RsData = ready ? slot[sel_idx].rs.data : '0;
    assign iq.Issue_RtData = ready ? slot[sel_idx].rt.data : '0;

endmodule

// File: tb/tb_int_issue_queue.sv
module tb_int_issue_queue;
    import int_issue_queue_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  rd;
        logic [TAG_W-1:0]  rs_tag;
        logic [DATA_W-1:0] rs_data;
        bit                rs_rdy;
        logic [TAG_W-1:0]  rt_tag;
        logic [DATA_W-1:0] rt_data;
        bit                rt_rdy;
    } m_t;

    logic Clk = 1'b0;
    logic Rst_n;
    logic Flush;
    int_issue_queue_if iqif ();

    int_issue_queue #(.DEPTH(DEPTH)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Flush (Flush),
        .iq    (iqif)
    );

    always #5 Clk = ~Clk;

    m_t mq[$];
    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic void m_sel(output bit found, output int idx);
        found = 0;
        idx   = 0;
        for (int i = 0; i < mq.size(); i++) begin
            if (!found && mq[i].rs_rdy && mq[i].rt_rdy) begin
                found = 1;
                idx   = i;
            end
        end
    endfunction

    // Model: age-ordered list. Flush wins. Otherwise issue pops the oldest ready entry,
    // the CDB wakes the survivors, and an accepted dispatch is appended with bypass.
    task automatic model_edge();
        bit f;
        int idx;
        bit was_full;
        m_t n;
        if (!Rst_n || Flush) begin
            mq.delete();
            return;
        end
        m_sel(f, idx);
        was_full = (mq.size() == DEPTH);
        if (iqif.Issue_Int && f) mq.delete(idx);
        if (iqif.CDB_Valid) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].rs_rdy && mq[i].rs_tag == iqif.CDB_Tag) begin
                    mq[i].rs_rdy = 1; mq[i].rs_data = iqif.CDB_Data;
                end
                if (!mq[i].rt_rdy && mq[i].rt_tag == iqif.CDB_Tag) begin
                    mq[i].rt_rdy = 1; mq[i].rt_data = iqif.CDB_Data;
                end
            end
        end
        if (iqif.Dispatch_Valid && !was_full) begin
            n.op = iqif.Dispatch_Opcode; n.rd = iqif.Dispatch_RdTag;
            n.rs_tag = iqif.Dispatch_RsTag; n.rs_data = iqif.Dispatch_RsData;
            n.rs_rdy = iqif.Dispatch_RsReady;
            n.rt_tag = iqif.Dispatch_RtTag; n.rt_data = iqif.Dispatch_RtData;
            n.rt_rdy = iqif.Dispatch_RtReady;
            if (iqif.CDB_Valid && !n.rs_rdy && n.rs_tag == iqif.CDB_Tag) begin
                n.rs_rdy = 1; n.rs_data = iqif.CDB_Data;
            end
            if (iqif.CDB_Valid && !n.rt_rdy && n.rt_tag == iqif.CDB_Tag) begin
                n.rt_rdy = 1; n.rt_data = iqif.CDB_Data;
            end
            mq.push_back(n);
        end
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge Clk) begin
        bit f;
        int idx;
        if (cmp_en) begin
            m_sel(f, idx);
            chk("ready", 32'(iqif.Ready_Int), 32'(f));
            chk("full", 32'(iqif.Queue_Full), 32'(mq.size() == DEPTH));
            chk("opcode", 32'(iqif.Issue_Opcode), f ? 32'(mq[idx].op) : 32'd0);
            chk("rdtag", 32'(iqif.Issue_RdTag), f ? 32'(mq[idx].rd) : 32'd0);
            chk("rsdata", iqif.Issue_RsData, f ? mq[idx].rs_data : 32'd0);
            chk("rtdata", iqif.Issue_RtData, f ? mq[idx].rt_data : 32'd0);
        end
    end

    task automatic idle();
        Flush = 0;
        iqif.Dispatch_Valid = 0; iqif.Dispatch_Opcode = '0; iqif.Dispatch_RdTag = '0;
        iqif.Dispatch_RsTag = '0; iqif.Dispatch_RsData = '0; iqif.Dispatch_RsReady = 0;
        iqif.Dispatch_RtTag = '0; iqif.Dispatch_RtData = '0; iqif.Dispatch_RtReady = 0;
        iqif.CDB_Valid = 0; iqif.CDB_Tag = '0; iqif.CDB_Data = '0;
        iqif.Issue_Int = 0;
    endtask

    task automatic disp(logic [3:0] op, logic [4:0] rd,
                        logic [4:0] rst, logic [31:0] rsd, bit rsr,
                        logic [4:0] rtt, logic [31:0] rtd, bit rtr);
        iqif.Dispatch_Valid = 1; iqif.Dispatch_Opcode = op; iqif.Dispatch_RdTag = rd;
        iqif.Dispatch_RsTag = rst; iqif.Dispatch_RsData = rsd; iqif.Dispatch_RsReady = rsr;
        iqif.Dispatch_RtTag = rtt; iqif.Dispatch_RtData = rtd; iqif.Dispatch_RtReady = rtr;
    endtask

    task automatic cdb(logic [4:0] t, logic [31:0] d);
        iqif.CDB_Valid = 1; iqif.CDB_Tag = t; iqif.CDB_Data = d;
    endtask

    // One clock: model follows the edge, then return at the following negedge.
    task automatic tick();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
    endtask

    task automatic do_reset();
        #2 Rst_n = 0;
        mq.delete();
        @(posedge Clk);
        @(negedge Clk);
        chk("rst_ready", 32'(iqif.Ready_Int), 32'd0);
        chk("rst_full", 32'(iqif.Queue_Full), 32'd0);
        chk("rst_opcode", 32'(iqif.Issue_Opcode), 32'd0);
        chk("rst_rsdata", iqif.Issue_RsData, 32'd0);
        Rst_n = 1;
    endtask

    initial begin
        Rst_n = 0;
        idle();
        repeat (2) @(negedge Clk);
        Rst_n = 1;
        cmp_en = 1;

        // Single fully-ready op issues the cycle after dispatch.
        disp(4'h3, 5'd5, 5'd0, 32'd10, 1, 5'd0, 32'd20, 1);
        tick(); idle();
        chk("t2_ready", 32'(iqif.Ready_Int), 32'd1);
        chk("t2_rs", iqif.Issue_RsData, 32'd10);
        chk("t2_rt", iqif.Issue_RtData, 32'd20);
        chk("t2_rd", 32'(iqif.Issue_RdTag), 32'd5);
        iqif.Issue_Int = 1;
        tick(); idle();
        chk("t2_after_issue", 32'(iqif.Ready_Int), 32'd0);
        chk("t2_count", 32'(mq.size()), 32'd0);

        // Wakeup: ready the cycle after the broadcast edge.
        disp(4'h1, 5'd6, 5'd7, 32'd0, 0, 5'd0, 32'd3, 1);
        tick(); idle();
        chk("t3_wait0", 32'(iqif.Ready_Int), 32'd0);
        tick();
        chk("t3_wait1", 32'(iqif.Ready_Int), 32'd0);
        cdb(5'd7, 32'hABCD);
        tick(); idle();
        chk("t3_ready", 32'(iqif.Ready_Int), 32'd1);
        chk("t3_rs", iqif.Issue_RsData, 32'h0000ABCD);
        iqif.Issue_Int = 1;
        tick(); idle();

        // Fill, middle entry ready, dispatch while full, issue with shift.
        disp(4'h1, 5'd11, 5'd1, 32'd0, 0, 5'd0, 32'd1, 1); tick();
        disp(4'h2, 5'd12, 5'd2, 32'd0, 0, 5'd0, 32'd2, 1); tick();
        disp(4'h7, 5'd13, 5'd0, 32'h22, 1, 5'd0, 32'h23, 1); tick();
        disp(4'h8, 5'd14, 5'd3, 32'd0, 0, 5'd0, 32'h24, 1); tick();
        chk("t4_full", 32'(iqif.Queue_Full), 32'd1);
        chk("t4_sel_op", 32'(iqif.Issue_Opcode), 32'h7);
        disp(4'h9, 5'd15, 5'd0, 32'd1, 1, 5'd0, 32'd1, 1);
        tick();
        chk("t4_drop_count", 32'(mq.size()), 32'd4);
        chk("t4_still_op", 32'(iqif.Issue_Opcode), 32'h7);
        iqif.Issue_Int = 1;
        tick(); idle();
        chk("t4_after_full", 32'(iqif.Queue_Full), 32'd0);
        chk("t4_count", 32'(mq.size()), 32'd3);
        chk("t4_none_ready", 32'(iqif.Ready_Int), 32'd0);
        cdb(5'd3, 32'h33);
        tick(); idle();
        chk("t4_shifted_op", 32'(iqif.Issue_Opcode), 32'h8);
        chk("t4_shifted_rs", iqif.Issue_RsData, 32'h33);

        // Flush beats simultaneous dispatch, issue and wakeup.
        Flush = 1; iqif.Issue_Int = 1; cdb(5'd1, 32'h77);
        disp(4'h5, 5'd1, 5'd0, 32'd1, 1, 5'd0, 32'd1, 1);
        tick(); idle();
        chk("t6_ready", 32'(iqif.Ready_Int), 32'd0);
        chk("t6_count", 32'(mq.size()), 32'd0);

        // Dispatch bypass from a same-cycle CDB.
        disp(4'h4, 5'd8, 5'd0, 32'd1, 1, 5'd9, 32'd0, 0);
        cdb(5'd9, 32'h55);
        tick(); idle();
        chk("t5_ready", 32'(iqif.Ready_Int), 32'd1);
        chk("t5_rt", iqif.Issue_RtData, 32'h55);
        iqif.Issue_Int = 1;
        tick(); idle();

        // Random traffic with occasional flush and mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            idle();
            if ($urandom_range(99) < 60)
                disp(4'($urandom), 5'($urandom), 5'($urandom_range(7)), $urandom,
                     1'($urandom_range(2) == 0), 5'($urandom_range(7)), $urandom,
                     1'($urandom_range(2) == 0));
            if ($urandom_range(99) < 50) cdb(5'($urandom_range(7)), $urandom);
            iqif.Issue_Int = 1'($urandom_range(99) < 45);
            Flush = 1'($urandom_range(99) < 2);
            if (c == 1500) begin
                do_reset();
            end else begin
                tick();
            end
        end

        idle();
        cmp_en = 0;
        @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
